// File: rtl/pio_serial_shifter.sv
// pio_serial_shifter: shifts the PIO parallel word out to a 74HC595-style chain whenever it changes
module pio_serial_shifter #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] par_in,
  input  logic                  force_update,
  output logic                  busy,
  output logic                  sr_clk,
  output logic                  sr_data,
  output logic                  sr_latch
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] shadow, shreg, last_sent, shreg_nxt;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] div_cnt;
  logic init_pending, div_end;
  assign div_end = div_cnt == DIV_LAST;
  assign shreg_nxt = MSB_FIRST ? shreg << 1 : shreg >> 1;
  function automatic logic head(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction
  // shreg holds the unsent tail so the outgoing bit is always at its head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      sr_clk <= 1'b0;
      sr_data <= 1'b0;
      sr_latch <= 1'b0;
      shadow <= '0;
      shreg <= '0;
      last_sent <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      init_pending <= 1'b1;
    end else begin
      case (state)
        IDLE: if (par_in != last_sent || force_update || init_pending) begin
          state <= SHIFT;
          busy <= 1'b1;
          shadow <= par_in;
          shreg <= par_in;
          sr_data <= head(par_in);
          bit_cnt <= '0;
          div_cnt <= '0;
          init_pending <= 1'b0;
        end
        SHIFT: if (!div_end) div_cnt <= div_cnt + 1'b1;
        else begin
          div_cnt <= '0;
          sr_clk <= !sr_clk;
          if (sr_clk && bit_cnt == BIT_LAST) begin
            state <= LATCH;
            sr_latch <= 1'b1;
            sr_data <= 1'b0;
          end else if (sr_clk) begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg <= shreg_nxt;
            sr_data <= head(shreg_nxt);
          end
        end
        LATCH: if (!div_end) div_cnt <= div_cnt + 1'b1;
        else begin
          div_cnt <= '0;
          state <= IDLE;
          busy <= 1'b0;
          sr_latch <= 1'b0;
          last_sent <= shadow;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pio_serial_shifter.sv
// tb_pio_serial_shifter: randomized checks of the serial shifter against a bit-order reference model
module tb_pio_serial_shifter;
  localparam int DW = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b1, frc_a = 1'b0, rst_b = 1'b1, frc_b = 1'b0;
  logic [DW-1:0] par_a = '0, par_b = '0;
  logic busy_a, clk_a, data_a, latch_a, busy_b, clk_b, data_b, latch_b;
  pio_serial_shifter #(.DATA_WIDTH(DW), .CLK_DIV(4), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(rst_a), .par_in(par_a), .force_update(frc_a),
    .busy(busy_a), .sr_clk(clk_a), .sr_data(data_a), .sr_latch(latch_a));
  pio_serial_shifter #(.DATA_WIDTH(DW), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(rst_b), .par_in(par_b), .force_update(frc_b),
    .busy(busy_b), .sr_clk(clk_b), .sr_data(data_b), .sr_latch(latch_b));
  bit sel = 1'b0;
  wire m_busy = sel ? busy_b : busy_a;
  wire m_clk = sel ? clk_b : clk_a;
  wire m_data = sel ? data_b : data_a;
  wire m_latch = sel ? latch_b : latch_a;
  int n_cmp = 0, n_err = 0;
  logic cap_bits[$];
  int cap_busy, cap_rises, cap_latch;
  bit cap_to, cap_unstable;
  logic [DW-1:0] last_a;

  // records one whole transfer as seen on the pins
  task automatic capture();
    int n = 0;
    logic prev_clk = 1'b0, prev_data = 1'b0;
    cap_bits = {};
    cap_busy = 0; cap_rises = 0; cap_latch = 0; cap_to = 0; cap_unstable = 0;
    while (!m_busy && n < 2000) begin @(negedge clk); n++; end
    if (!m_busy) begin cap_to = 1; return; end
    n = 0;
    while (m_busy && n < 2000) begin
      cap_busy++;
      if (m_clk && !prev_clk) begin cap_bits.push_back(m_data); cap_rises++; end
      if (m_clk && m_data !== prev_data) cap_unstable = 1;
      if (m_latch) cap_latch++;
      prev_clk = m_clk; prev_data = m_data; n++;
      @(negedge clk);
    end
    if (m_busy) cap_to = 1;
  endtask

  function automatic logic [DW-1:0] cap_seq();
    logic [DW-1:0] w = '0;
    for (int k = 0; k < DW && k < cap_bits.size(); k++) w[k] = cap_bits[k];
    return w;
  endfunction

  // element k = k-th bit that should appear on the wire
  function automatic logic [DW-1:0] send_order(input logic [DW-1:0] v, input bit msb);
    logic [DW-1:0] s;
    for (int k = 0; k < DW; k++) s[k] = msb ? v[DW-1-k] : v[k];
    return s;
  endfunction

  function automatic logic [DW-1:0] fresh(input logic [DW-1:0] avoid);
    logic [DW-1:0] v;
    do v = DW'($urandom); while (v == avoid || v == 16'h1234);
    return v;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_a, clk_a, data_a, latch_a} !== 4'b0) begin
      n_err++; $display("FAIL reset_a got %b exp 0000", {busy_a, clk_a, data_a, latch_a});
    end
    n_cmp++;
    if ({busy_b, clk_b, data_b, latch_b} !== 4'b0) begin
      n_err++; $display("FAIL reset_b got %b exp 0000", {busy_b, clk_b, data_b, latch_b});
    end
  endtask

  task automatic test_init();
    sel = 0;
    rst_a = 0;
    capture();
    n_cmp++; if (cap_to) begin n_err++; $display("FAIL init_timeout got 1 exp 0"); end
    n_cmp++; if (cap_seq() !== 16'h0000) begin n_err++; $display("FAIL init_word got %h exp 0000", cap_seq()); end
    n_cmp++; if (cap_busy !== 132) begin n_err++; $display("FAIL init_busy got %0d exp 132", cap_busy); end
    n_cmp++; if (cap_rises !== 16) begin n_err++; $display("FAIL init_rises got %0d exp 16", cap_rises); end
    n_cmp++; if (cap_latch !== 4) begin n_err++; $display("FAIL init_latch got %0d exp 4", cap_latch); end
    last_a = '0;
  endtask

  task automatic test_pattern();
    logic [DW-1:0] v;
    sel = 0;
    for (int i = 0; i < 5; i++) begin
      v = (i == 0) ? 16'hA5C3 : fresh(last_a);
      par_a = v;
      capture();
      n_cmp++;
      if (cap_seq() !== send_order(v, 1)) begin
        n_err++; $display("FAIL pattern_bits[%0d] got %h exp %h", i, cap_seq(), send_order(v, 1));
      end
      n_cmp++; if (cap_busy !== 132) begin n_err++; $display("FAIL pattern_busy[%0d] got %0d exp 132", i, cap_busy); end
      n_cmp++; if (cap_unstable) begin n_err++; $display("FAIL pattern_stable[%0d] got 1 exp 0", i); end
      last_a = v;
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    sel = 0;
    par_a = 16'h1234;
    fork
      capture();
      begin
        repeat (20) @(negedge clk); par_a = 16'h5678;
        repeat (40) @(negedge clk); par_a = 16'h9ABC;
      end
    join
    n_cmp++;
    if (cap_seq() !== send_order(16'h1234, 1)) begin
      n_err++; $display("FAIL b2b_first got %h exp %h", cap_seq(), send_order(16'h1234, 1));
    end
    capture();
    n_cmp++;
    if (cap_seq() !== send_order(16'h9ABC, 1)) begin
      n_err++; $display("FAIL b2b_final got %h exp %h", cap_seq(), send_order(16'h9ABC, 1));
    end
    repeat (300) begin @(negedge clk); if (busy_a) seen = 1; end
    n_cmp++; if (seen) begin n_err++; $display("FAIL b2b_quiet got busy exp idle"); end
    last_a = 16'h9ABC;
  endtask

  task automatic test_force();
    bit seen = 0;
    sel = 0;
    par_a = 16'h00FF;
    capture();
    n_cmp++; if (cap_seq() !== send_order(16'h00FF, 1)) begin n_err++; $display("FAIL force_setup got %h", cap_seq()); end
    frc_a = 1; @(negedge clk); frc_a = 0;
    capture();
    n_cmp++;
    if (cap_to || cap_seq() !== send_order(16'h00FF, 1)) begin
      n_err++; $display("FAIL force_resend got %h to=%0d exp %h", cap_seq(), cap_to, send_order(16'h00FF, 1));
    end
    fork
      capture();
      begin repeat (30) @(negedge clk); frc_a = 1; @(negedge clk); frc_a = 0; end
    join
    repeat (300) begin @(negedge clk); if (busy_a) seen = 1; end
    n_cmp++; if (seen) begin n_err++; $display("FAIL force_busy_ignored got busy exp idle"); end
    seen = 0;
    par_a = 16'h0F0F; frc_a = 1; @(negedge clk); frc_a = 0;
    capture();
    n_cmp++; if (cap_seq() !== send_order(16'h0F0F, 1)) begin n_err++; $display("FAIL force_combo got %h", cap_seq()); end
    repeat (300) begin @(negedge clk); if (busy_a) seen = 1; end
    n_cmp++; if (seen) begin n_err++; $display("FAIL force_combo_once got busy exp idle"); end
    last_a = 16'h0F0F;
  endtask

  task automatic test_reset_mid();
    int n = 0, r = 0;
    logic prev = 0;
    sel = 0;
    par_a = 16'h3C3C;
    while (r < 8 && n < 2000) begin
      @(negedge clk); n++;
      if (clk_a && !prev) r++;
      prev = clk_a;
    end
    n_cmp++; if (r !== 8) begin n_err++; $display("FAIL mid_reach got %0d exp 8", r); end
    #2 rst_a = 1;
    #1;
    n_cmp++;
    if ({busy_a, clk_a, data_a, latch_a} !== 4'b0) begin
      n_err++; $display("FAIL mid_async got %b exp 0000", {busy_a, clk_a, data_a, latch_a});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy_a, clk_a, data_a, latch_a} !== 4'b0) begin
      n_err++; $display("FAIL mid_edge got %b exp 0000", {busy_a, clk_a, data_a, latch_a});
    end
    repeat (3) @(negedge clk);
    rst_a = 0;
    capture();
    n_cmp++;
    if (cap_to || cap_seq() !== send_order(16'h3C3C, 1)) begin
      n_err++; $display("FAIL mid_reinit got %h exp %h", cap_seq(), send_order(16'h3C3C, 1));
    end
  endtask

  task automatic test_clkdiv1();
    logic [DW-1:0] v, prev_v;
    sel = 1;
    par_b = 16'h0001;
    @(negedge clk);
    rst_b = 0;
    prev_v = '0;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 16'h0001 : fresh(prev_v);
      par_b = v;
      capture();
      if (i == 0) begin
        n_cmp++; if (cap_bits.size() == 0 || cap_bits[0] !== 1'b1) begin n_err++; $display("FAIL div1_first_bit got %h exp 1", cap_seq()); end
        n_cmp++; if (cap_latch !== 1) begin n_err++; $display("FAIL div1_latch got %0d exp 1", cap_latch); end
      end
      n_cmp++; if (cap_busy !== 33) begin n_err++; $display("FAIL div1_busy[%0d] got %0d exp 33", i, cap_busy); end
      n_cmp++;
      if (cap_seq() !== send_order(v, 0)) begin
        n_err++; $display("FAIL div1_bits[%0d] got %h exp %h", i, cap_seq(), send_order(v, 0));
      end
      prev_v = v;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_pattern();
    test_back_to_back();
    test_force();
    test_reset_mid();
    test_clkdiv1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
